// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared receive-PHY types and K28.5 constants
//
// Purpose: aligner state encoding and the two K28.5 comma symbols, shared
//          between comma_aligner and the 8b/10b decoder.
// Ports:   none (package).

package phy_pkg;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    CANDIDATE = 2'd1,
    LOCKED    = 2'd2
  } align_state_e;

  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;

  // 4-bit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/comma_aligner_if.sv
// rtl/comma_aligner_if.sv - word stream in / aligned stream out bundle
//
// Purpose: groups the deserializer input, the aligned output and the lock
//          status of comma_aligner.
// Signals: data_in/in_valid/realign_en (master -> aligner),
//          data_out/rx_valid/comma_pulse/locked/align_offset (aligner -> master).

interface comma_aligner_if #(
  parameter int W     = 10,
  parameter int OFF_W = $clog2(W)
);
  logic [W-1:0]     data_in;
  logic             in_valid;
  logic             realign_en;
  logic [W-1:0]     data_out;
  logic             rx_valid;
  logic             comma_pulse;
  logic             locked;
  logic [OFF_W-1:0] align_offset;

  modport master (
    output data_in, in_valid, realign_en,
    input  data_out, rx_valid, comma_pulse, locked, align_offset
  );

  modport slave (
    input  data_in, in_valid, realign_en,
    output data_out, rx_valid, comma_pulse, locked, align_offset
  );
endinterface

// File: rtl/comma_aligner_match_array.sv
// rtl/comma_aligner_match_array.sv - comma search over every bit offset of a two-word window
//
// Purpose: combinational compare of each W-bit slice of win against both
//          comma patterns.
// Ports:   win (2W-bit window, older word in the low half),
//          match (per-offset hit vector), hit (any match),
//          hit_off (lowest matching offset, 0 when no hit).

module comma_match_array
  import phy_pkg::*;
#(
  parameter int             W       = 10,
  parameter logic [W-1:0]   COMMA_N = W'(K28_5_RDN),
  parameter logic [W-1:0]   COMMA_P = W'(K28_5_RDP),
  parameter int             OFF_W   = $clog2(W)
) (
  input  logic [2*W-1:0]   win,
  output logic [W-1:0]     match,
  output logic             hit,
  output logic [OFF_W-1:0] hit_off
);

  always_comb begin
    match = '0;
    for (int k = 0; k < W; k++) begin
      match[k] = (win[k +: W] == COMMA_N) || (win[k +: W] == COMMA_P);
    end
  end

  // Scan from the top down so the lowest matching offset is the last write.
  always_comb begin
    hit_off = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit_off = OFF_W'(k);
      end
    end
  end

  assign hit = |match;

endmodule

// File: rtl/comma_aligner.sv
// rtl/comma_aligner.sv - word-boundary aligner between deserializer and 8b/10b decoder
//
// Purpose: finds comma symbols at any bit offset, qualifies lock over
//          LOCK_CNT same-offset commas, tolerates isolated misaligned commas
//          and emits re-aligned words one clock after each input word.
// Ports:   clk, rst_n (asynchronous, active low),
//          bus (slave side of comma_aligner_if: data_in/in_valid/realign_en in,
//          data_out/rx_valid/comma_pulse/locked/align_offset out).

module comma_aligner
  import phy_pkg::*;
#(
  parameter int             W          = 10,
  parameter logic [W-1:0]   COMMA_N    = W'(K28_5_RDN),
  parameter logic [W-1:0]   COMMA_P    = W'(K28_5_RDP),
  parameter int             LOCK_CNT   = 3,
  parameter int             UNLOCK_ERR = 4,
  parameter int             MAX_GAP    = 0,
  parameter int             OFF_W      = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  comma_aligner_if.slave bus
);

  localparam int GAP_W = (MAX_GAP > 1) ? $clog2(MAX_GAP + 1) : 1;

  align_state_e     state_q, state_d;
  logic [W-1:0]     prev_word_q, prev_word_d;
  logic [OFF_W-1:0] cand_off_q, cand_off_d;
  logic [OFF_W-1:0] align_offset_q, align_offset_d;
  logic [3:0]       cand_cnt_q, cand_cnt_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [W-1:0]     data_out_q, data_out_d;
  logic             rx_valid_q, rx_valid_d;
  logic             comma_pulse_q, comma_pulse_d;

  logic [2*W-1:0]   win;
  logic [W-1:0]     match;
  logic             hit;
  logic [OFF_W-1:0] hit_off;

  // Older word sits in the low half because bit 0 is received first.
  assign win = {bus.data_in, prev_word_q};

  comma_match_array #(
    .W       (W),
    .COMMA_N (COMMA_N),
    .COMMA_P (COMMA_P),
    .OFF_W   (OFF_W)
  ) u_match (
    .win     (win),
    .match   (match),
    .hit     (hit),
    .hit_off (hit_off)
  );

  always_comb begin
    state_d        = state_q;
    prev_word_d    = prev_word_q;
    cand_off_d     = cand_off_q;
    align_offset_d = align_offset_q;
    cand_cnt_d     = cand_cnt_q;
    err_cnt_d      = err_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    data_out_d     = data_out_q;
    rx_valid_d     = 1'b0;
    comma_pulse_d  = 1'b0;

    if (bus.in_valid) begin
      prev_word_d = bus.data_in;

      unique case (state_q)
        UNLOCKED: begin
          if (hit) begin
            cand_off_d = hit_off;
            cand_cnt_d = 4'd1;
            if (LOCK_CNT == 1) begin
              state_d        = LOCKED;
              align_offset_d = hit_off;
              cand_cnt_d     = '0;
              err_cnt_d      = '0;
              gap_cnt_d      = '0;
            end else begin
              state_d = CANDIDATE;
            end
          end
        end

        CANDIDATE: begin
          if (hit) begin
            if (hit_off == cand_off_q) begin
              cand_cnt_d = sat_inc4(cand_cnt_q);
              if (cand_cnt_d >= 4'(LOCK_CNT)) begin
                state_d        = LOCKED;
                align_offset_d = cand_off_q;
                cand_cnt_d     = '0;
                err_cnt_d      = '0;
                gap_cnt_d      = '0;
              end
            end else begin
              cand_off_d = hit_off;
              cand_cnt_d = 4'd1;
            end
          end
        end

        LOCKED: begin
          // The locked offset is tested directly so that a lower-offset
          // comma in the same window cannot mask an aligned one.
          if (match[align_offset_q]) begin
            err_cnt_d = '0;
            gap_cnt_d = '0;
          end else if (hit && bus.realign_en) begin
            err_cnt_d = sat_inc4(err_cnt_q);
          end else begin
            gap_cnt_d = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + 1'b1;
          end

          if ((err_cnt_d == 4'(UNLOCK_ERR)) ||
              ((MAX_GAP != 0) && (gap_cnt_d == GAP_W'(MAX_GAP)))) begin
            state_d    = UNLOCKED;
            cand_cnt_d = '0;
            err_cnt_d  = '0;
            gap_cnt_d  = '0;
          end
        end

        default: begin
          state_d = UNLOCKED;
        end
      endcase

      // Slice with the next-state offset so the locking word itself comes
      // out already aligned.
      data_out_d    = win[align_offset_d +: W];
      rx_valid_d    = (state_d == LOCKED);
      comma_pulse_d = rx_valid_d && ((data_out_d == COMMA_N) || (data_out_d == COMMA_P));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= UNLOCKED;
      prev_word_q    <= '0;
      cand_off_q     <= '0;
      align_offset_q <= '0;
      cand_cnt_q     <= '0;
      err_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      data_out_q     <= '0;
      rx_valid_q     <= 1'b0;
      comma_pulse_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_word_q    <= prev_word_d;
      cand_off_q     <= cand_off_d;
      align_offset_q <= align_offset_d;
      cand_cnt_q     <= cand_cnt_d;
      err_cnt_q      <= err_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      data_out_q     <= data_out_d;
      rx_valid_q     <= rx_valid_d;
      comma_pulse_q  <= comma_pulse_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.comma_pulse  = comma_pulse_q;
  assign bus.locked       = (state_q == LOCKED);
  assign bus.align_offset = align_offset_q;

endmodule

// File: tb/tb_comma_aligner.sv
// tb/tb_comma_aligner.sv - directed self-checking bench for comma_aligner

module tb_comma_aligner;
  import phy_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [19:0] drv_data;
  logic        drv_valid;
  logic        drv_realign;
  int          sel;

  comma_aligner_if #(.W(10)) if_a ();
  comma_aligner_if #(.W(10)) if_b ();
  comma_aligner_if #(.W(20)) if_c ();

  assign if_a.data_in    = drv_data[9:0];
  assign if_a.in_valid   = drv_valid && (sel == 0);
  assign if_a.realign_en = drv_realign;
  assign if_b.data_in    = drv_data[9:0];
  assign if_b.in_valid   = drv_valid && (sel == 1);
  assign if_b.realign_en = drv_realign;
  assign if_c.data_in    = drv_data;
  assign if_c.in_valid   = drv_valid && (sel == 2);
  assign if_c.realign_en = drv_realign;

  comma_aligner #(.W(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  comma_aligner #(.W(10), .MAX_GAP(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  comma_aligner #(.W(20), .COMMA_N(20'hC3A51), .COMMA_P(20'hA5C3B)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  int n_chk = 0;
  int n_err = 0;

  logic        bitq[$];
  logic [19:0] sym_at[int];
  int          pos, word_cnt, wn, grp_ctr, data_ctr, ww;

  logic [19:0] obs_data;
  logic        obs_valid, obs_pulse, obs_locked;
  logic [4:0]  obs_off;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (word %0d)", tag, got, exp, wn);
    end
  endtask

  task automatic sample();
    case (sel)
      0: begin
        obs_data = {10'd0, if_a.data_out}; obs_valid = if_a.rx_valid; obs_pulse = if_a.comma_pulse;
        obs_locked = if_a.locked; obs_off = {1'b0, if_a.align_offset};
      end
      1: begin
        obs_data = {10'd0, if_b.data_out}; obs_valid = if_b.rx_valid; obs_pulse = if_b.comma_pulse;
        obs_locked = if_b.locked; obs_off = {1'b0, if_b.align_offset};
      end
      default: begin
        obs_data = if_c.data_out; obs_valid = if_c.rx_valid; obs_pulse = if_c.comma_pulse;
        obs_locked = if_c.locked; obs_off = if_c.align_offset;
      end
    endcase
  endtask

  function automatic logic is_comma(input logic [19:0] s);
    if (ww == 20) return (s == 20'hC3A51) || (s == 20'hA5C3B);
    return (s == {10'd0, K28_5_RDN}) || (s == {10'd0, K28_5_RDP});
  endfunction

  task automatic push_sym(input logic [19:0] s);
    sym_at[pos] = s;
    for (int b = 0; b < ww; b++) bitq.push_back(s[b]);
    pos += ww;
  endtask

  task automatic push_data();
    push_sym((ww == 20) ? 20'd0 : 20'((data_ctr % 15) + 1));
    data_ctr++;
  endtask

  task automatic push_group();
    if (ww == 20) push_sym(grp_ctr[0] ? 20'hA5C3B : 20'hC3A51);
    else          push_sym(grp_ctr[0] ? {10'd0, K28_5_RDP} : {10'd0, K28_5_RDN});
    grp_ctr++;
    repeat (4) push_data();
  endtask

  task automatic align_to(input int k);
    while ((pos % ww) != k) begin
      bitq.push_back(1'b0);
      pos++;
    end
  endtask

  task automatic send_word();
    logic [19:0] w;
    w = '0;
    for (int b = 0; b < ww; b++) w[b] = bitq.pop_front();
    drv_data  = w;
    drv_valid = 1'b1;
    @(posedge clk);
    #1;
    sample();
    wn = word_cnt;
    word_cnt++;
  endtask

  task automatic expect_word(input string tag, input int off);
    int key;
    key = (wn - 1) * ww + off;
    check({tag, "_sym_exists"}, sym_at.exists(key), 1);
    if (sym_at.exists(key)) begin
      check({tag, "_data"}, obs_data, sym_at[key]);
      check({tag, "_pulse"}, obs_pulse, is_comma(sym_at[key]));
    end
  endtask

  task automatic do_reset();
    drv_valid = 1'b0;
    rst_n     = 1'b0;
    bitq.delete();
    sym_at.delete();
    pos = 0; word_cnt = 0; wn = 0; grp_ctr = 0; data_ctr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_realign(input logic en);
    logic exp;
    do_reset();
    sel = 0; ww = 10; drv_realign = en;
    align_to(3);
    repeat (7) push_group();
    while (bitq.size() >= ww) send_word();
    check(en ? "t2_pre_locked" : "t3_pre_locked", obs_locked, 1);
    align_to(7);
    repeat (8) push_group();
    while (bitq.size() >= ww) begin
      send_word();
      if (en) begin
        exp = (wn < 51) || (wn >= 66);
        check("t2_locked", obs_locked, exp);
        check("t2_rx_valid", obs_valid, exp);
        if (wn >= 66) begin
          check("t2_offset", obs_off, 7);
          expect_word("t2", 7);
        end
      end else begin
        check("t3_locked", obs_locked, 1);
        check("t3_offset", obs_off, 3);
        check("t3_pulse", obs_pulse, 0);
      end
    end
  endtask

  initial begin
    logic        exp;
    logic [19:0] held;
    sel = 0; ww = 10; drv_data = '0; drv_realign = 1'b1;
    do_reset();

    // Reset state
    sample();
    check("rst_data", obs_data, 0);
    check("rst_rx_valid", obs_valid, 0);
    check("rst_pulse", obs_pulse, 0);
    check("rst_locked", obs_locked, 0);
    check("rst_offset", obs_off, 0);

    // Lock at offset 3 on the third comma, then aligned symbols pass through
    align_to(3);
    repeat (7) push_group();
    while (bitq.size() >= ww) begin
      send_word();
      exp = (wn >= 11);
      check("t1_locked", obs_locked, exp);
      check("t1_rx_valid", obs_valid, exp);
      if (exp) begin
        check("t1_offset", obs_off, 3);
        expect_word("t1", 3);
      end else begin
        check("t1_pulse_unlocked", obs_pulse, 0);
      end
    end

    // Misaligned commas: counted with realign_en=1, ignored with realign_en=0
    run_realign(1'b1);
    run_realign(1'b0);

    // Asynchronous reset while locked
    drv_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    sample();
    check("arst_data", obs_data, 0);
    check("arst_rx_valid", obs_valid, 0);
    check("arst_pulse", obs_pulse, 0);
    check("arst_locked", obs_locked, 0);
    check("arst_offset", obs_off, 0);

    // Commas alternating between offsets 2 and 5 never qualify
    do_reset();
    sel = 0; ww = 10; drv_realign = 1'b1;
    for (int g = 0; g < 8; g++) begin
      align_to(g[0] ? 5 : 2);
      push_group();
    end
    while (bitq.size() >= ww) begin
      send_word();
      check("t4_locked", obs_locked, 0);
      check("t4_rx_valid", obs_valid, 0);
    end

    // MAX_GAP=8: idle cycles hold state, eighth comma-free word unlocks
    do_reset();
    sel = 1; ww = 10; drv_realign = 1'b1;
    align_to(3);
    repeat (3) push_group();
    repeat (12) push_data();
    while (bitq.size() >= ww) begin
      send_word();
      exp = (wn >= 11) && (wn < 19);
      check("t5_locked", obs_locked, exp);
      check("t5_rx_valid", obs_valid, exp);
      if (exp) expect_word("t5", 3);
      if (wn == 14) begin
        held = obs_data;
        drv_valid = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          sample();
          check("t5_gap_rx_valid", obs_valid, 0);
          check("t5_gap_pulse", obs_pulse, 0);
          check("t5_gap_locked", obs_locked, 1);
          check("t5_gap_data_hold", obs_data, held);
        end
      end
    end

    // W=20 with 20-bit commas, lock at offset 17
    do_reset();
    sel = 2; ww = 20; drv_realign = 1'b1;
    align_to(17);
    repeat (4) push_group();
    while (bitq.size() >= ww) begin
      send_word();
      exp = (wn >= 11);
      check("t6_locked", obs_locked, exp);
      if (exp) begin
        check("t6_offset", obs_off, 17);
        expect_word("t6", 17);
      end
    end

    drv_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
- Parametrised successor to the fixed 10-bit comma detector: word-boundary aligner for the receive PHY path.
- Sits between serial_to_parallel and the 8b/10b decoder.
- Searches a two-word window for either comma pattern at every bit offset, qualifies lock over several consecutive commas at one offset, and holds lock through isolated misaligned commas.
- Emits re-aligned words, a registered comma pulse and rx_valid.

Parameters:
- W, 10, symbol width in bits (>=4).
- COMMA_N, 10'h0FA, comma pattern, running disparity negative (W bits).
- COMMA_P, 10'h305, comma pattern, running disparity positive (W bits).
- LOCK_CNT, 3, consecutive same-offset commas needed to lock (1..15).
- UNLOCK_ERR, 4, misaligned commas while locked before lock is dropped (1..15).
- MAX_GAP, 0, words without a comma while locked before unlock; 0 disables.
- OFF_W, $clog2(W), width of the offset field.

Ports:
- clk, in, 1, word clock.
- rst_n, in, 1, asynchronous active-low reset.
- data_in, in, W, unaligned word from the deserializer; bit 0 is first received.
- in_valid, in, 1, data_in is a new word this cycle.
- realign_en, in, 1, 1 = a misaligned comma while locked is counted as an error; 0 = ignored.
- data_out, out, W, aligned word.
- rx_valid, out, 1, data_out is valid and the aligner is locked.
- comma_pulse, out, 1, data_out is a comma at the locked offset.
- locked, out, 1, state == LOCKED.
- align_offset, out, OFF_W, committed bit offset.

Behaviour:
- Reset: prev_word=0, state=UNLOCKED, all counters=0, align_offset=0, data_out=0, rx_valid=0, comma_pulse=0, locked=0.
- in_valid=0: prev_word, state and counters hold; next cycle rx_valid=0 and comma_pulse=0; data_out holds.
- Window: win = {data_in, prev_word}, 2W bits. prev_word <= data_in on every in_valid.
- Match at offset k (0..W-1): win[k+W-1:k] == COMMA_N or COMMA_P. hit = any match; hit_off = lowest matching k.
- States:
  - UNLOCKED: on hit, cand_off=hit_off and cand_cnt=1, then go to CANDIDATE. If LOCK_CNT==1, go straight to LOCKED with align_offset=hit_off.
  - CANDIDATE, hit at cand_off: cand_cnt++. When cand_cnt reaches LOCK_CNT, go to LOCKED with align_offset=cand_off and err_cnt=gap_cnt=0.
  - CANDIDATE, hit at another offset: restart with cand_off=hit_off and cand_cnt=1.
  - CANDIDATE, no hit: hold.
  - LOCKED:
    - A match at align_offset (checked independently of hit_off priority) clears err_cnt and gap_cnt.
    - Else, if hit and realign_en, err_cnt++.
    - Else, gap_cnt++ (saturating).
    - err_cnt==UNLOCK_ERR, or MAX_GAP!=0 and gap_cnt==MAX_GAP, goes to UNLOCKED and clears all counters.
- Output register, updated on in_valid:
  - data_out = win[off+W-1:off], where off is the next-state offset. In the lock cycle this is the newly committed offset; otherwise it is align_offset.
  - rx_valid = next_state==LOCKED.
  - comma_pulse = rx_valid and data_out equals a comma.
- Latency: 1 clk from the in_valid word to data_out, rx_valid and comma_pulse.
- Simultaneous match at the locked offset and another offset counts as aligned (no error).
- The unlock cycle itself outputs rx_valid=0.
- Counters saturate and never wrap.
- Reset asserted mid-lock: all outputs go to reset values immediately, and relock requires LOCK_CNT new commas.
- Comparisons are pure bit equality; there is no disparity tracking in this block.

Decomposition:
- Package phy_pkg holds the aligner state enum (UNLOCKED, CANDIDATE, LOCKED) and the K28.5 constants K28_5_RDN=10'h0FA and K28_5_RDP=10'h305, shared with the decoder.
- One sub-module: comma_match_array (combinational, W offsets → hit, hit_off, match vector). The FSM and output register stay in comma_aligner.

Test Plan:
- Reset, then a stream with K28.5 at offset 3 every 5 words; LOCK_CNT=3 → locked=1 and align_offset=3 one clk after the 3rd comma. From then, comma_pulse=1 exactly on the aligned 0x0FA/0x305 words, and data_out equals the original unshifted symbols.
- Lock at offset 3, then 4 commas at offset 7 with realign_en=1 → unlock on the 4th, then relock at offset 7 after 3 more.
- Same stimulus with realign_en=0 → remains locked at offset 3 with no errors counted.
- Alternating commas at offsets 2 and 5 while unlocked → never reaches LOCKED; cand_cnt stays ≤1.
- MAX_GAP=8, locked, then 8 non-comma words → locked and rx_valid fall after the 8th word. in_valid gaps of 3 cycles mid-stream cause no state change, and rx_valid=0 during the gaps.
- Assert rst_n low while locked → all outputs 0 asynchronously. W=20 with 20-bit patterns: lock at offset 17 succeeds.
